// File: rtl/block_ram_data_arbiter.sv
// Command-port arbiter and layer-burst sequencer for the activation RAM.
// Define WR_PREEMPT_EN to let single writes preempt reads inside a burst.
module block_ram_data_arbiter #(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int ADDR_WIDTH                    = 5,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_valid,
    input  logic [LAYER_WIDTH-1:0] i_wr_layer,
    input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    output logic                   o_wr_ready,
    output logic                   o_wr_err,
    input  logic                   i_rd_start,
    input  logic [LAYER_WIDTH-1:0] i_rd_layer,
    output logic                   o_rd_busy,
    output logic                   o_rd_done,
    output logic                   o_ram_enable,
    output logic                   o_ram_rw_select,
    output logic [LAYER_WIDTH-1:0] o_ram_layer,
    output logic [ADDR_WIDTH-1:0]  o_ram_addr,
    output logic [DATA_WIDTH-1:0]  o_ram_data,
    input  logic                   i_ram_data_valid
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                 state;
    logic                   last_rd;
    logic [LAYER_WIDTH-1:0] rd_layer;
    logic [CW-1:0]          addr_cnt;
    logic [CW-1:0]          ret_cnt;
    logic [CW-1:0]          rd_n;
    logic [CW-1:0]          wr_n;
    logic                   wr_ok;
    logic                   rd_grant;
    logic                   wr_grant;

    function automatic logic [CW-1:0] node_count(input logic [LAYER_WIDTH-1:0] layer);
        logic [CW-1:0] n;
        if (layer == LAYER_WIDTH'(0))
            n = CW'(NUMBER_OF_INPUT_NODE);
        else if (layer == LAYER_WIDTH'(1))
            n = CW'(NUMBER_OF_HIDDEN_NODE_LAYER_1);
        else if (layer == LAYER_WIDTH'(2))
            n = CW'(NUMBER_OF_HIDDEN_NODE_LAYER_2);
        else
            n = CW'(NUMBER_OF_OUTPUT_NODE);
        return n;
    endfunction

    always_comb begin
        rd_n     = node_count(rd_layer);
        wr_n     = node_count(i_wr_layer);
        wr_ok    = {1'b0, i_wr_addr} < wr_n;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    // On a tie the requester that did not win last time goes first
                    rd_grant = i_rd_start && (!i_wr_valid || !last_rd);
                    wr_grant = i_wr_valid && !rd_grant;
                end
                READ: begin
`ifdef WR_PREEMPT_EN
                    wr_grant = i_wr_valid;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_wr_ready = wr_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_rd         <= 1'b1;
            rd_layer        <= '0;
            addr_cnt        <= '0;
            ret_cnt         <= '0;
            o_wr_err        <= 1'b0;
            o_rd_busy       <= 1'b0;
            o_rd_done       <= 1'b0;
            o_ram_enable    <= 1'b0;
            o_ram_rw_select <= 1'b0;
            o_ram_layer     <= '0;
            o_ram_addr      <= '0;
            o_ram_data      <= '0;
        end else begin
            o_ram_enable <= 1'b0;
            o_wr_err     <= 1'b0;
            o_rd_done    <= 1'b0;

            if (wr_grant) begin
                last_rd <= 1'b0;
                if (wr_ok) begin
                    o_ram_enable    <= 1'b1;
                    o_ram_rw_select <= 1'b0;
                    o_ram_layer     <= i_wr_layer;
                    o_ram_addr      <= i_wr_addr;
                    o_ram_data      <= i_wr_data;
                end else begin
                    o_wr_err <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (rd_grant) begin
                        rd_layer  <= i_rd_layer;
                        addr_cnt  <= '0;
                        ret_cnt   <= '0;
                        o_rd_busy <= 1'b1;
                        last_rd   <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (i_ram_data_valid)
                        ret_cnt <= ret_cnt + CW'(1);
                    // A preempting write takes this slot; addr_cnt holds
                    if (!wr_grant) begin
                        o_ram_enable    <= 1'b1;
                        o_ram_rw_select <= 1'b1;
                        o_ram_layer     <= rd_layer;
                        o_ram_addr      <= addr_cnt[ADDR_WIDTH-1:0];
                        o_ram_data      <= '0;
                        addr_cnt        <= addr_cnt + CW'(1);
                        if (addr_cnt == rd_n - CW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ret_cnt == rd_n) begin
                        o_rd_done <= 1'b1;
                        o_rd_busy <= 1'b0;
                        state     <= IDLE;
                    end else if (i_ram_data_valid) begin
                        ret_cnt <= ret_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_ram_data_arbiter.sv
// Randomized bench for block_ram_data_arbiter against a transaction-level
// schedule model; a simple RAM model returns read-valid one cycle after a read.
module tb_block_ram_data_arbiter;

`ifdef WR_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wr_valid;
    logic [1:0]  i_wr_layer;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_wr_ready;
    logic        o_wr_err;
    logic        i_rd_start;
    logic [1:0]  i_rd_layer;
    logic        o_rd_busy;
    logic        o_rd_done;
    logic        o_ram_enable;
    logic        o_ram_rw_select;
    logic [1:0]  o_ram_layer;
    logic [4:0]  o_ram_addr;
    logic [31:0] o_ram_data;
    logic        i_ram_data_valid;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    int   cyc;
    bit   m_busy;
    bit   m_last_rd;
    int   m_layer;
    int   m_done_at;
    int   rdq[$];

    block_ram_data_arbiter dut (
        .clk(clk),
        .rst(rst),
        .i_wr_valid(i_wr_valid),
        .i_wr_layer(i_wr_layer),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready),
        .o_wr_err(o_wr_err),
        .i_rd_start(i_rd_start),
        .i_rd_layer(i_rd_layer),
        .o_rd_busy(o_rd_busy),
        .o_rd_done(o_rd_done),
        .o_ram_enable(o_ram_enable),
        .o_ram_rw_select(o_ram_rw_select),
        .o_ram_layer(o_ram_layer),
        .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data),
        .i_ram_data_valid(i_ram_data_valid)
    );

    always #5 clk = ~clk;

    function automatic int n_of(input int layer);
        case (layer)
            0: return 2;
            1: return 32;
            2: return 32;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_last_rd = 1'b1;
        m_layer   = 0;
        m_done_at = -1;
        rdq.delete();
    endtask

    task automatic step(input logic wv, input logic [1:0] wl, input logic [4:0] wa,
                        input logic [31:0] wd, input logic rs, input logic [1:0] rl);
        bit          idle;
        bit          rd_win;
        bit          rdy;
        bit          e_en;
        bit          e_rw;
        bit          e_err;
        bit          e_done;
        logic [1:0]  e_l;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        @(negedge clk);
        i_ram_data_valid = o_ram_enable && o_ram_rw_select;
        i_wr_valid = wv;
        i_wr_layer = wl;
        i_wr_addr  = wa;
        i_wr_data  = wd;
        i_rd_start = rs;
        i_rd_layer = rl;
        #1;
        idle   = !m_busy;
        rd_win = 1'b0;
        rdy    = 1'b0;
        if (idle) begin
            rd_win = rs && (!wv || !m_last_rd);
            rdy    = wv && !rd_win;
        end else if (PREEMPT && rdq.size() > 0) begin
            rdy = wv;
        end
        check("wr_ready", 64'(o_wr_ready), 64'(rdy));
        e_en = 0; e_rw = 0; e_err = 0; e_done = 0;
        e_l = '0; e_a = '0; e_d = '0;
        if (rdy) begin
            m_last_rd = 1'b0;
            if (int'(wa) < n_of(int'(wl))) begin
                e_en = 1; e_l = wl; e_a = wa; e_d = wd;
            end else begin
                e_err = 1;
            end
        end
        if (rd_win) begin
            m_busy    = 1'b1;
            m_layer   = int'(rl);
            m_last_rd = 1'b1;
            for (int i = 0; i < n_of(int'(rl)); i++) rdq.push_back(i);
        end else if (m_busy && rdq.size() > 0 && !rdy) begin
            e_en = 1; e_rw = 1;
            e_l  = 2'(m_layer);
            e_a  = 5'(rdq.pop_front());
            e_d  = '0;
            if (rdq.size() == 0) m_done_at = cyc + 2;
        end
        if (m_busy && cyc == m_done_at) begin
            e_done = 1;
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        check("ram_enable", 64'(o_ram_enable), 64'(e_en));
        if (e_en) begin
            check("ram_rw", 64'(o_ram_rw_select), 64'(e_rw));
            check("ram_layer", 64'(o_ram_layer), 64'(e_l));
            check("ram_addr", 64'(o_ram_addr), 64'(e_a));
            if (!e_rw) check("ram_data", 64'(o_ram_data), 64'(e_d));
        end
        check("wr_err", 64'(o_wr_err), 64'(e_err));
        check("rd_done", 64'(o_rd_done), 64'(e_done));
        check("rd_busy", 64'(o_rd_busy), 64'(m_busy));
        cyc++;
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 2'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && m_busy; i++) idle_step();
        if (m_busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_wr_ready), 64'd0);
        check({tag, "_en"}, 64'(o_ram_enable), 64'd0);
        check({tag, "_busy"}, 64'(o_rd_busy), 64'd0);
        check({tag, "_done"}, 64'(o_rd_done), 64'd0);
        check({tag, "_err"}, 64'(o_wr_err), 64'd0);
        check({tag, "_cmd"}, {o_ram_rw_select, o_ram_layer, o_ram_addr, o_ram_data}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_layer = 2'd1;
        i_wr_addr  = 5'd0;
        i_wr_data  = '0;
        i_rd_start = 1'b1;
        i_rd_layer = 2'd0;
        i_ram_data_valid = 1'b0;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        i_wr_valid = 1'b0;
        i_rd_start = 1'b0;

        // tie right after reset: write first, then burst
        step(1'b1, 2'd1, 5'd5, 32'h3F80_0000, 1'b1, 2'd3);
        step(1'b1, 2'd2, 5'd7, 32'h1234_5678, 1'b1, 2'd3);
        wait_idle();
        idle_step();
        // out-of-range and top-of-range writes
        step(1'b1, 2'd3, 5'd3, 32'hDEAD_BEEF, 1'b0, 2'd0);
        step(1'b1, 2'd1, 5'd31, 32'hCAFE_F00D, 1'b0, 2'd0);
        step(1'b1, 2'd0, 5'd2, 32'h0000_0001, 1'b0, 2'd0);
        // full 32-node burst, with a write offered at burst cycle 10
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd1);
        for (int i = 1; i < 10; i++) idle_step();
        step(1'b1, 2'd2, 5'd9, 32'hA5A5_5A5A, 1'b0, 2'd0);
        wait_idle();
        // back-to-back bursts
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd0);
        wait_idle();
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd3);
        wait_idle();

        for (int i = 0; i < 600; i++) begin
            step(1'(($urandom % 3) == 0), 2'($urandom), 5'($urandom), $urandom,
                 1'(($urandom % 8) == 0), 2'($urandom));
        end
        wait_idle();

        // reset during burst cycle 4
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd1);
        for (int i = 0; i < 4; i++) idle_step();
        @(negedge clk);
        rst = 1'b1;
        i_wr_valid = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst = 1'b0;
        i_wr_valid = 1'b0;
        i_ram_data_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) idle_step();
        step(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd3);
        wait_idle();
        idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
